// File: rtl/masking_pkg.sv
// Shared masking helpers: randomness indexing, share slicing, per-gadget random word count.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package masking_pkg;

  // Number of fresh random words a DOM AND gadget with d shares needs.
  function automatic int num_rand(input int d);
    return d * (d - 1) / 2;
  endfunction

  // Random word index for the share pair {i,j} with j < i.
  // Every masked gadget must use this so the randomness layout is identical.
  function automatic int rand_idx(input int i, input int j);
    return j + i * (i - 1) / 2;
  endfunction

  // LSB position of share s on a bus of w-bit shares.
  function automatic int share_lsb(input int s, input int w);
    return s * w;
  endfunction

endpackage

// File: rtl/dom_and_stage.sv
// Stateless DOM AND product array: all D*D cross-domain terms, refreshed where i != j.
// Latency: combinational.
// Backpressure: none; the caller gates the registers that capture the products.
module dom_and_stage
  import masking_pkg::*;
#(
  parameter int D = 2,
  parameter int W = 1,
  parameter int Z = num_rand(D)
) (
  input  logic [D*W-1:0]   a,
  input  logic [D*W-1:0]   b,
  input  logic [Z*W-1:0]   rdi,
  output logic [D*D*W-1:0] p
);

  logic [W-1:0] term;

  // Term (i,j) lands at slot i*D+j; the inner-domain terms stay unrefreshed.
  always_comb begin
    p    = '0;
    term = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        term = a[share_lsb(i, W) +: W] & b[share_lsb(j, W) +: W];
        if (i > j) begin
          term = term ^ rdi[share_lsb(rand_idx(i, j), W) +: W];
        end else if (i < j) begin
          term = term ^ rdi[share_lsb(rand_idx(j, i), W) +: W];
        end
        p[share_lsb(i * D + j, W) +: W] = term;
      end
    end
  end

endmodule

// File: rtl/dom_and_stream.sv
// Streaming DOM AND gadget with operand/randomness handshake and starvation counter (option: DOM_AND_OUTREG_EN).
// Latency: 1 cycle accept-to-out_valid_o, 2 cycles with DOM_AND_OUTREG_EN.
// Backpressure: stalls hold all registers (no product re-evaluation); randomness is consumed only together with operands.
module dom_and_stream
  import masking_pkg::*;
#(
  parameter int D  = 2,
  parameter int W  = 1,
  parameter int Z  = num_rand(D),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [D*W-1:0] a_i,
  input  logic [D*W-1:0] b_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [Z*W-1:0] rdi_i,
  input  logic          rdi_valid_i,
  output logic          rdi_ready_o,
  output logic [D*W-1:0] c_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  input  logic          flush_i,
  output logic [CW-1:0] starve_cnt_o
);

  localparam int PW = D * D * W;

  logic [PW-1:0]  p_d;
  logic [PW-1:0]  p_q;
  logic           s1_valid;
  logic [D*W-1:0] c_s1;
  logic           adv;
  logic           acc;
  logic           starve;
  logic [CW-1:0]  starve_cnt;

  dom_and_stage #(
    .D (D),
    .W (W),
    .Z (Z)
  ) u_stage (
    .a   (a_i),
    .b   (b_i),
    .rdi (rdi_i),
    .p   (p_d)
  );

  assign in_ready_o  = !s1_valid | adv;
  assign acc         = in_valid_i & rdi_valid_i & in_ready_o & !flush_i;
  assign rdi_ready_o = acc;
  assign starve      = in_valid_i & !rdi_valid_i & in_ready_o;

  // S1 product registers load only on accept, so they never toggle while stalled or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (acc) begin
      p_q <= p_d;
    end
  end

  // S1 valid: flush wins, then a new accept, then a drain empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (acc) begin
      s1_valid <= 1'b1;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Share compression straight from the registered terms.
  always_comb begin
    c_s1 = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        c_s1[share_lsb(i, W) +: W] = c_s1[share_lsb(i, W) +: W] ^ p_q[share_lsb(i * D + j, W) +: W];
      end
    end
  end

`ifdef DOM_AND_OUTREG_EN
  logic           s2_valid;
  logic [D*W-1:0] c_q;

  assign adv         = !s2_valid | out_ready_i;
  assign c_o         = c_q;
  assign out_valid_o = s2_valid;

  // S2 valid follows S1 whenever S2 can advance; flush empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (flush_i) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
    end
  end

  // S2 data loads only when a real S1 result moves up, keeping c_o flop-driven and quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
    end else if (adv && s1_valid && !flush_i) begin
      c_q <= c_s1;
    end
  end
`else
  assign adv         = out_ready_i;
  assign c_o         = c_s1;
  assign out_valid_o = s1_valid;
`endif

  // Saturating count of cycles where operands wait on randomness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (starve && (starve_cnt != {CW{1'b1}})) begin
      starve_cnt <= starve_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign starve_cnt_o = starve_cnt;

endmodule

// File: tb/tb_dom_and_stream.sv
// Directed bench for dom_and_stream: a D=2/W=4 instance with a 4-bit counter and a D=3/W=8 instance.
// Latency: checks assume the default single-register build.
// Backpressure: exercised via out_ready, rdi_valid starvation, flush and mid-stream reset.
module tb_dom_and_stream;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  // D=2, W=4, CW=4 instance
  logic [7:0] a2, b2, c2;
  logic [3:0] rdi2, sc2;
  logic       inv2, rv2, ordy2, fl2, ir2, rr2, ov2;

  // D=3, W=8, CW=16 instance
  logic [23:0] a3, b3, c3, rdi3;
  logic [15:0] sc3;
  logic        inv3, rv3, ordy3, fl3, ir3, rr3, ov3;

  dom_and_stream #(.D(2), .W(4), .CW(4)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_i          (a2),
    .b_i          (b2),
    .in_valid_i   (inv2),
    .in_ready_o   (ir2),
    .rdi_i        (rdi2),
    .rdi_valid_i  (rv2),
    .rdi_ready_o  (rr2),
    .c_o          (c2),
    .out_valid_o  (ov2),
    .out_ready_i  (ordy2),
    .flush_i      (fl2),
    .starve_cnt_o (sc2)
  );

  dom_and_stream #(.D(3), .W(8), .CW(16)) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_i          (a3),
    .b_i          (b3),
    .in_valid_i   (inv3),
    .in_ready_o   (ir3),
    .rdi_i        (rdi3),
    .rdi_valid_i  (rv3),
    .rdi_ready_o  (rr3),
    .c_o          (c3),
    .out_valid_o  (ov3),
    .out_ready_i  (ordy3),
    .flush_i      (fl3),
    .starve_cnt_o (sc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] unmask3(input logic [23:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  task automatic test_reset();
    #2;
    tests++; if (ir2 !== 1'b1) begin fails++; $display("FAIL reset_in_ready2: got %b want 1", ir2); end
    tests++; if (rr2 !== 1'b0) begin fails++; $display("FAIL reset_rdi_ready2: got %b want 0", rr2); end
    tests++; if (ov2 !== 1'b0) begin fails++; $display("FAIL reset_out_valid2: got %b want 0", ov2); end
    tests++; if (c2 !== 8'h00) begin fails++; $display("FAIL reset_c2: got %h want 00", c2); end
    tests++; if (sc2 !== 4'h0) begin fails++; $display("FAIL reset_starve2: got %h want 0", sc2); end
    tests++; if (ir3 !== 1'b1) begin fails++; $display("FAIL reset_in_ready3: got %b want 1", ir3); end
    tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL reset_out_valid3: got %b want 0", ov3); end
    tests++; if (c3 !== 24'h0) begin fails++; $display("FAIL reset_c3: got %h want 000000", c3); end
    tests++; if (sc3 !== 16'h0) begin fails++; $display("FAIL reset_starve3: got %h want 0000", sc3); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector();
    @(negedge clk);
    a2 = {4'h3, 4'hA}; b2 = {4'hC, 4'h5}; rdi2 = 4'h6;
    inv2 = 1'b1; rv2 = 1'b1; ordy2 = 1'b1;
    #1;
    tests++; if (rr2 !== 1'b1) begin fails++; $display("FAIL vec_rdi_ready: got %b want 1", rr2); end
    @(negedge clk);
    inv2 = 1'b0; rv2 = 1'b0;
    #1;
    tests++; if (ov2 !== 1'b1) begin fails++; $display("FAIL vec_out_valid: got %b want 1", ov2); end
    tests++; if (c2 !== {4'h7, 4'hE}) begin fails++; $display("FAIL vec_shares: got %h want 7e", c2); end
    tests++; if ((c2[3:0] ^ c2[7:4]) !== 4'h9) begin fails++; $display("FAIL vec_unmask: got %h want 9", c2[3:0] ^ c2[7:4]); end
    @(negedge clk);
    #1;
    tests++; if (ov2 !== 1'b0) begin fails++; $display("FAIL vec_drained: got %b want 0", ov2); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    bit         have;
    have = 0; exp_q = '0;
    inv3 = 1'b1; rv3 = 1'b1; ordy3 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (have) begin
        tests++; if (ov3 !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %b want 1", n, ov3); end
        tests++; if (unmask3(c3) !== exp_q) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", n, unmask3(c3), exp_q); end
      end
      a3 = 24'($urandom); b3 = 24'($urandom); rdi3 = 24'($urandom);
      exp_q = unmask3(a3) & unmask3(b3);
      have = 1;
      #1;
      tests++; if (rr3 !== 1'b1) begin fails++; $display("FAIL b2b_rdi_ready[%0d]: got %b want 1", n, rr3); end
    end
    @(negedge clk);
    tests++; if (ov3 !== 1'b1) begin fails++; $display("FAIL b2b_last_valid: got %b want 1", ov3); end
    tests++; if (unmask3(c3) !== exp_q) begin fails++; $display("FAIL b2b_last_data: got %h want %h", unmask3(c3), exp_q); end
    inv3 = 1'b0; rv3 = 1'b0;
    @(negedge clk);
    #1;
    tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b want 0", ov3); end
  endtask

  task automatic test_stall();
    logic [23:0] c_hold;
    c_hold = '0;
    // X: a = 12^34^56 = 70, b = FF^0F^AA = 5A, a&b = 50
    @(negedge clk);
    a3 = {8'h56, 8'h34, 8'h12}; b3 = {8'hAA, 8'h0F, 8'hFF}; rdi3 = 24'h9A7E15;
    inv3 = 1'b1; rv3 = 1'b1; ordy3 = 1'b0;
    #1;
    tests++; if (rr3 !== 1'b1) begin fails++; $display("FAIL stall_accept: got %b want 1", rr3); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      // Y: a = 11^22^44 = 77, b = 0F^F0^3C = C3, a&b = 43
      a3 = {8'h44, 8'h22, 8'h11}; b3 = {8'h3C, 8'hF0, 8'h0F}; rdi3 = 24'h3C5AE1;
      #1;
      if (k == 0) c_hold = c3;
      tests++; if (ov3 !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b want 1", k, ov3); end
      tests++; if (unmask3(c3) !== 8'h50) begin fails++; $display("FAIL stall_data[%0d]: got %h want 50", k, unmask3(c3)); end
      tests++; if (c3 !== c_hold) begin fails++; $display("FAIL stall_stable[%0d]: got %h want %h", k, c3, c_hold); end
      tests++; if (ir3 !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, ir3); end
      tests++; if (rr3 !== 1'b0) begin fails++; $display("FAIL stall_rdi_ready[%0d]: got %b want 0", k, rr3); end
    end
    @(negedge clk);
    ordy3 = 1'b1;
    #1;
    tests++; if (unmask3(c3) !== 8'h50) begin fails++; $display("FAIL release_data: got %h want 50", unmask3(c3)); end
    tests++; if (ir3 !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", ir3); end
    tests++; if (rr3 !== 1'b1) begin fails++; $display("FAIL release_rdi_ready: got %b want 1", rr3); end
    @(negedge clk);
    inv3 = 1'b0; rv3 = 1'b0;
    #1;
    tests++; if (ov3 !== 1'b1) begin fails++; $display("FAIL release_next_valid: got %b want 1", ov3); end
    tests++; if (unmask3(c3) !== 8'h43) begin fails++; $display("FAIL release_next_data: got %h want 43", unmask3(c3)); end
    @(negedge clk);
    #1;
    tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL release_drained: got %b want 0", ov3); end
  endtask

  task automatic test_starve();
    @(negedge clk);
    inv3 = 1'b1; rv3 = 1'b0; ordy3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      tests++; if (rr3 !== 1'b0) begin fails++; $display("FAIL starve_rdi_ready[%0d]: got %b want 0", k, rr3); end
      tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL starve_out_valid[%0d]: got %b want 0", k, ov3); end
      @(negedge clk);
    end
    inv3 = 1'b0;
    #1;
    tests++; if (sc3 !== 16'd7) begin fails++; $display("FAIL starve_count: got %0d want 7", sc3); end
    tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL starve_no_output: got %b want 0", ov3); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    inv2 = 1'b1; rv2 = 1'b0; ordy2 = 1'b1;
    repeat (14) @(negedge clk);
    #1;
    tests++; if (sc2 !== 4'hE) begin fails++; $display("FAIL sat_before: got %h want e", sc2); end
    repeat (6) @(negedge clk);
    #1;
    tests++; if (sc2 !== 4'hF) begin fails++; $display("FAIL sat_hold: got %h want f", sc2); end
    tests++; if (rr2 !== 1'b0) begin fails++; $display("FAIL sat_rdi_ready: got %b want 0", rr2); end
    inv2 = 1'b0;
  endtask

  task automatic test_flush();
    // P: a = FF, b = 0F
    @(negedge clk);
    a3 = {8'h00, 8'h00, 8'hFF}; b3 = {8'h00, 8'h00, 8'h0F}; rdi3 = 24'h123456;
    inv3 = 1'b1; rv3 = 1'b1; ordy3 = 1'b1; fl3 = 1'b0;
    #1;
    tests++; if (rr3 !== 1'b1) begin fails++; $display("FAIL flush_first_accept: got %b want 1", rr3); end
    @(negedge clk);
    a3 = {8'h00, 8'h00, 8'hAA}; b3 = {8'h00, 8'h00, 8'hFF}; fl3 = 1'b1;
    #1;
    tests++; if (ov3 !== 1'b1) begin fails++; $display("FAIL flush_pending: got %b want 1", ov3); end
    tests++; if (rr3 !== 1'b0) begin fails++; $display("FAIL flush_rdi_ready: got %b want 0", rr3); end
    @(negedge clk);
    fl3 = 1'b0; inv3 = 1'b0; rv3 = 1'b0;
    #1;
    tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL flush_cleared: got %b want 0", ov3); end
    // R: a = 24^42^81 = E7, b = F0^3C^0F = C3, a&b = C3
    @(negedge clk);
    a3 = {8'h81, 8'h42, 8'h24}; b3 = {8'h0F, 8'h3C, 8'hF0}; rdi3 = 24'hA5C3E7;
    inv3 = 1'b1; rv3 = 1'b1;
    #1;
    tests++; if (rr3 !== 1'b1) begin fails++; $display("FAIL flush_after_accept: got %b want 1", rr3); end
    @(negedge clk);
    inv3 = 1'b0; rv3 = 1'b0;
    #1;
    tests++; if (ov3 !== 1'b1) begin fails++; $display("FAIL flush_after_valid: got %b want 1", ov3); end
    tests++; if (unmask3(c3) !== 8'hC3) begin fails++; $display("FAIL flush_after_data: got %h want c3", unmask3(c3)); end
  endtask

  task automatic test_midreset();
    @(negedge clk);
    a3 = {8'h5A, 8'h3C, 8'hF0}; b3 = {8'h0F, 8'hFF, 8'h11}; rdi3 = 24'h77AA55;
    inv3 = 1'b1; rv3 = 1'b1; ordy3 = 1'b0;
    @(negedge clk);
    inv3 = 1'b0; rv3 = 1'b0;
    #1;
    tests++; if (ov3 !== 1'b1) begin fails++; $display("FAIL mid_pending: got %b want 1", ov3); end
    rst_n = 1'b0;
    #1;
    tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", ov3); end
    tests++; if (c3 !== 24'h0) begin fails++; $display("FAIL mid_c: got %h want 000000", c3); end
    tests++; if (ir3 !== 1'b1) begin fails++; $display("FAIL mid_in_ready: got %b want 1", ir3); end
    tests++; if (rr3 !== 1'b0) begin fails++; $display("FAIL mid_rdi_ready: got %b want 0", rr3); end
    tests++; if (sc3 !== 16'h0) begin fails++; $display("FAIL mid_starve3: got %h want 0000", sc3); end
    tests++; if (sc2 !== 4'h0) begin fails++; $display("FAIL mid_starve2: got %h want 0", sc2); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      tests++; if (ov3 !== 1'b0) begin fails++; $display("FAIL mid_spurious3[%0d]: got %b want 0", k, ov3); end
      tests++; if (ov2 !== 1'b0) begin fails++; $display("FAIL mid_spurious2[%0d]: got %b want 0", k, ov2); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    a2 = '0; b2 = '0; rdi2 = '0; inv2 = 1'b0; rv2 = 1'b0; ordy2 = 1'b0; fl2 = 1'b0;
    a3 = '0; b3 = '0; rdi3 = '0; inv3 = 1'b0; rv3 = 1'b0; ordy3 = 1'b0; fl3 = 1'b0;
    test_reset();
    test_vector();
    test_back_to_back();
    test_stall();
    test_starve();
    test_saturate();
    test_flush();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
